// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
//   Parametrised SPI master. A request on the recv val/rdy interface carries a
//   right-aligned word. The low N bits of that word are shifted out MSB-first
//   on mosi while the peripheral selected by the chip-select address register
//   is held low. The N bits sampled from miso are returned right-aligned on
//   the send val/rdy interface.
//
//   Optional feature macro: SPI_MASTER_MODE_EN
//     defined   : adds cpol/cpha inputs, latched per transaction at the request
//                 handshake.
//     undefined : fixed SPI mode 0 (CPOL=0, CPHA=0).
//
// Ports:
//   clk             system clock, all logic on posedge
//   reset           asynchronous reset, active low
//   recv_val/rdy    request handshake
//   recv_msg        data to transmit, right-aligned
//   send_val/rdy    response handshake
//   send_msg        received data, right-aligned, upper bits zero
//   packet_size_*   bits-per-transaction write (0 or >BIT_WIDTH -> BIT_WIDTH)
//   cs_addr_*       chip-select index write
//   cs              active-low chip selects
//   sclk, mosi      SPI clock and serial data out
//   miso            serial data in
//   cpol, cpha      SPI mode (only with SPI_MASTER_MODE_EN)
// -----------------------------------------------------------------------------
module spi_master_param #(
    parameter int BIT_WIDTH   = 32,
    parameter int N_CS        = 1,
    parameter int HALF_PERIOD = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   recv_val,
    output logic                                   recv_rdy,
    input  logic [BIT_WIDTH-1:0]                   recv_msg,
    output logic                                   send_val,
    input  logic                                   send_rdy,
    output logic [BIT_WIDTH-1:0]                   send_msg,
    input  logic                                   packet_size_val,
    input  logic [$clog2(BIT_WIDTH):0]             packet_size_msg,
    input  logic                                   cs_addr_val,
    input  logic [((N_CS > 1) ? $clog2(N_CS) : 1)-1:0] cs_addr_msg,
    output logic [N_CS-1:0]                        cs,
    output logic                                   sclk,
    output logic                                   mosi,
    input  logic                                   miso
`ifdef SPI_MASTER_MODE_EN
    ,
    input  logic                                   cpol,
    input  logic                                   cpha
`endif
);

    localparam int PW  = $clog2(BIT_WIDTH) + 1;
    localparam int CAW = (N_CS > 1) ? $clog2(N_CS) : 1;
    localparam int TW  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [PW-1:0] BW_P   = PW'(BIT_WIDTH);
    localparam logic [TW-1:0] T_LAST = TW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {IDLE, START, LEAD, TRAIL, CS_WAIT, DONE} state_t;

    // Size register always holds an effective length in 1..BIT_WIDTH, so
    // zero and oversize writes both collapse to the full width here.
    function automatic logic [PW-1:0] sat_size(input logic [PW-1:0] v);
        if (v == '0 || v > BW_P) return BW_P;
        return v;
    endfunction

    state_t               state_q, state_d;
    logic [TW-1:0]        tcnt_q;
    logic [PW-1:0]        bitcnt_q;
    logic [PW-1:0]        size_q;
    logic [CAW-1:0]       cs_addr_q;
    logic [BIT_WIDTH-1:0] shreg_q;
    logic [BIT_WIDTH-1:0] rx_q;
    logic                 mosi_q;
    logic                 cpol_q, cpha_q;
    logic                 cpol_in, cpha_in;

    logic                 idle_rdy, cs_act, lead, accept;
    logic                 last_tick, last_bit;
    logic                 lead_end, trail_end, to_lead;
    logic [PW-1:0]        n_eff;
    logic [BIT_WIDTH-1:0] aligned;

`ifdef SPI_MASTER_MODE_EN
    assign cpol_in = cpol;
    assign cpha_in = cpha;
`else
    assign cpol_in = 1'b0;
    assign cpha_in = 1'b0;
`endif

    assign last_tick = (tcnt_q == T_LAST);
    assign last_bit  = (bitcnt_q == size_q - PW'(1));
    assign lead_end  = (state_q == LEAD)  && last_tick;
    assign trail_end = (state_q == TRAIL) && last_tick;
    assign to_lead   = last_tick && ((state_q == START) || ((state_q == TRAIL) && !last_bit));

    // A size write in the handshake cycle applies to this transaction.
    assign n_eff   = packet_size_val ? sat_size(packet_size_msg) : size_q;
    // Left-align the packet so its MSB is always at the top of the shifter;
    // bits above N fall off the top.
    assign aligned = recv_msg << (BW_P - n_eff);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        idle_rdy = 1'b0;
        send_val = 1'b0;
        cs_act   = 1'b0;
        lead     = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                idle_rdy = 1'b1;
                if (recv_val) begin
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cs_act = 1'b1;
                if (last_tick) state_d = LEAD;
            end
            LEAD: begin
                cs_act = 1'b1;
                lead   = 1'b1;
                if (last_tick) state_d = TRAIL;
            end
            TRAIL: begin
                cs_act = 1'b1;
                if (last_tick) state_d = last_bit ? CS_WAIT : LEAD;
            end
            CS_WAIT: begin
                cs_act = 1'b1;
                if (last_tick) state_d = DONE;
            end
            DONE: begin
                send_val = 1'b1;
                if (send_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset idles the
    // bus in the same cycle it is asserted.
    assign recv_rdy = idle_rdy & reset;
    assign sclk     = lead ? ~cpol_q : cpol_q;
    assign mosi     = cs_act & mosi_q;
    assign send_msg = rx_q;

    always_comb begin
        cs = '1;
        for (int i = 0; i < N_CS; i++) begin
            cs[i] = !(cs_act && (cs_addr_q == CAW'(i)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q    <= '0;
            bitcnt_q  <= '0;
            size_q    <= BW_P;
            cs_addr_q <= '0;
            shreg_q   <= '0;
            rx_q      <= '0;
            mosi_q    <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
        end else begin
            if (cs_act) tcnt_q <= last_tick ? '0 : tcnt_q + TW'(1);
            else        tcnt_q <= '0;

            if (idle_rdy) begin
                if (packet_size_val) size_q    <= sat_size(packet_size_msg);
                if (cs_addr_val)     cs_addr_q <= cs_addr_msg;
            end

            if (accept) begin
                bitcnt_q <= '0;
                rx_q     <= '0;
                cpol_q   <= cpol_in;
                cpha_q   <= cpha_in;
                // CPHA=0 presents the first bit during START; CPHA=1 holds
                // mosi low until the first leading edge.
                if (cpha_in) begin
                    mosi_q  <= 1'b0;
                    shreg_q <= aligned;
                end else begin
                    mosi_q  <= aligned[BIT_WIDTH-1];
                    shreg_q <= aligned << 1;
                end
            end

            if (cpha_q ? trail_end : lead_end)
                rx_q <= (rx_q << 1) | BIT_WIDTH'(miso);

            // CPHA=0 keeps the last bit on mosi through CS_WAIT.
            if (cpha_q ? to_lead : (lead_end && !last_bit))
                {mosi_q, shreg_q} <= {shreg_q, 1'b0};

            if (trail_end) bitcnt_q <= bitcnt_q + PW'(1);
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// -----------------------------------------------------------------------------
// tb_spi_master_param
//   Self-checking bench for spi_master_param (BIT_WIDTH=32, N_CS=4,
//   HALF_PERIOD=2). A bus monitor counts chip-select low cycles, SCLK pulses,
//   collects the bits seen on mosi and drives miso (random, loopback or tied
//   high). Expected values come from the SPI transaction rules: N pulses,
//   (2N+2)*H cycles of chip select, mosi = data[N-1:0] MSB first, and
//   send_msg = the N bits offered on miso.
// -----------------------------------------------------------------------------
module tb_spi_master_param;

    localparam int BW  = 32;
    localparam int NCS = 4;
    localparam int H   = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            recv_val = 1'b0;
    logic            recv_rdy;
    logic [BW-1:0]   recv_msg = '0;
    logic            send_val;
    logic            send_rdy = 1'b0;
    logic [BW-1:0]   send_msg;
    logic            packet_size_val = 1'b0;
    logic [5:0]      packet_size_msg = '0;
    logic            cs_addr_val = 1'b0;
    logic [1:0]      cs_addr_msg = '0;
    logic [NCS-1:0]  cs;
    logic            sclk, mosi, miso;
    logic            miso_drv = 1'b0;
    int              miso_mode = 0;   // 0 random, 1 loopback, 2 driven constant
    logic            cpol_tb = 1'b0, cpha_tb = 1'b0;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int          cs_low[NCS];
    int          pulses, mosi_n, miso_n, viol;
    logic [31:0] mosi_word, miso_word;
    logic        prev_sclk = 1'b0, prev_act = 1'b0, prev_mosi = 1'b0, act;

    assign miso = (miso_mode == 1) ? mosi : miso_drv;

    always #5 clk = ~clk;

    spi_master_param #(.BIT_WIDTH(BW), .N_CS(NCS), .HALF_PERIOD(H)) dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
        .packet_size_val(packet_size_val), .packet_size_msg(packet_size_msg),
        .cs_addr_val(cs_addr_val), .cs_addr_msg(cs_addr_msg),
        .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
`ifdef SPI_MASTER_MODE_EN
        , .cpol(cpol_tb), .cpha(cpha_tb)
`endif
    );

    function automatic logic [31:0] mask_n(input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return m[31:0];
    endfunction

    task automatic clear_mon();
        for (int i = 0; i < NCS; i++) cs_low[i] = 0;
        pulses = 0; mosi_n = 0; miso_n = 0; viol = 0;
        mosi_word = '0; miso_word = '0;
    endtask

    always @(negedge clk) begin
        act = (cs != '1);
        for (int i = 0; i < NCS; i++) if (cs[i] === 1'b0) cs_low[i]++;
        if (prev_act && act && sclk !== prev_sclk) begin
            if (sclk !== cpol_tb) begin
                pulses++;
                if (!cpha_tb) begin mosi_word = {mosi_word[30:0], mosi}; mosi_n++; end
                if (miso_mode == 0) begin
                    miso_drv  = 1'($urandom_range(0, 1));
                    miso_word = {miso_word[30:0], miso_drv};
                    miso_n++;
                end
            end else if (cpha_tb) begin
                mosi_word = {mosi_word[30:0], mosi}; mosi_n++;
            end
        end
        // mosi may only change on a falling SCLK edge while selected
        if (prev_act && act && mosi !== prev_mosi && !(prev_sclk === 1'b1 && sclk === 1'b0)) viol++;
        prev_act = act; prev_sclk = sclk; prev_mosi = mosi;
    end

    task automatic xfer(input logic [31:0] data, input logic psz_v, input logic [5:0] psz,
                        input logic ca_v, input logic [1:0] ca, output int lat);
        int k;
        @(posedge clk); #1;
        k = 0;
        while (recv_rdy !== 1'b1 && k < 200) begin @(posedge clk); #1; k++; end
        clear_mon();
        recv_val = 1'b1; recv_msg = data;
        packet_size_val = psz_v; packet_size_msg = psz;
        cs_addr_val = ca_v; cs_addr_msg = ca;
        @(posedge clk); #1;
        recv_val = 1'b0; packet_size_val = 1'b0; cs_addr_val = 1'b0; recv_msg = $urandom;
        lat = -1;
        for (int c = 1; c <= 4000; c++) begin
            @(negedge clk);
            if (send_val === 1'b1) begin lat = c; break; end
        end
    endtask

    task automatic ack();
        send_rdy = 1'b1;
        @(posedge clk); #1;
        send_rdy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (cs !== 4'hF) begin errors++; $display("FAIL rst_cs: got %0h expected f", cs); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %0b expected 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %0b expected 0", mosi); end
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL rst_send_val: got %0b expected 0", send_val); end
        checks++; if (recv_rdy !== 1'b0) begin errors++; $display("FAIL rst_recv_rdy: got %0b expected 0", recv_rdy); end
        checks++; if (send_msg !== 32'h0) begin errors++; $display("FAIL rst_send_msg: got %0h expected 0", send_msg); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL rst_release_rdy: got %0b expected 1", recv_rdy); end
    endtask

    task automatic test_mode0();
        int lat;
        miso_mode = 1;
        xfer(32'hA5, 1'b1, 6'd8, 1'b1, 2'd0, lat);
        checks++; if (lat !== 37) begin errors++; $display("FAIL m0_latency: got %0d expected 37", lat); end
        checks++; if (cs_low[0] !== 36) begin errors++; $display("FAIL m0_cs_low: got %0d expected 36", cs_low[0]); end
        checks++; if (pulses !== 8) begin errors++; $display("FAIL m0_pulses: got %0d expected 8", pulses); end
        checks++; if (mosi_n !== 8 || mosi_word !== 32'hA5) begin errors++; $display("FAIL m0_mosi: got %0d bits %0h expected 8 bits a5", mosi_n, mosi_word); end
        checks++; if (send_msg !== 32'hA5) begin errors++; $display("FAIL m0_send_msg: got %0h expected a5", send_msg); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL m0_mosi_edge: got %0d expected 0", viol); end
        ack();
    endtask

    task automatic test_size_cs();
        int lat, exp_low;
        miso_mode = 2; miso_drv = 1'b1;
        xfer(32'hF3, 1'b1, 6'd4, 1'b1, 2'd2, lat);
        for (int i = 0; i < NCS; i++) begin
            exp_low = (i == 2) ? 20 : 0;
            checks++; if (cs_low[i] !== exp_low) begin errors++; $display("FAIL sz_cs_low[%0d]: got %0d expected %0d", i, cs_low[i], exp_low); end
        end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL sz_pulses: got %0d expected 4", pulses); end
        checks++; if (mosi_n !== 4 || mosi_word !== 32'h3) begin errors++; $display("FAIL sz_mosi: got %0d bits %0h expected 4 bits 3", mosi_n, mosi_word); end
        checks++; if (send_msg !== 32'hF) begin errors++; $display("FAIL sz_send_msg: got %0h expected f", send_msg); end
        ack();
    endtask

    task automatic test_backpressure();
        int lat, bad, p0;
        miso_mode = 0;
        xfer($urandom, 1'b0, 6'd0, 1'b0, 2'd0, lat);
        checks++; if (pulses !== 4) begin errors++; $display("FAIL bp_pulses: got %0d expected 4", pulses); end
        checks++; if (send_msg !== miso_word) begin errors++; $display("FAIL bp_send_msg: got %0h expected %0h", send_msg, miso_word); end
        recv_val = 1'b1; recv_msg = $urandom;
        p0 = pulses; bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (send_val !== 1'b1 || recv_rdy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stall: got %0d bad cycles expected 0", bad); end
        checks++; if (pulses !== p0) begin errors++; $display("FAIL bp_sclk: got %0d pulses expected %0d", pulses, p0); end
        send_rdy = 1'b1;
        @(posedge clk); #1;
        send_rdy = 1'b0;
        checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_after: got %0b expected 1", recv_rdy); end
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL bp_val_after: got %0b expected 0", send_val); end
        recv_val = 1'b0;
    endtask

    task automatic test_packet_size();
        int lat;
        miso_mode = 0;
        xfer($urandom, 1'b1, 6'd16, 1'b1, 2'd1, lat);
        checks++; if (pulses !== 16) begin errors++; $display("FAIL ps16_pulses: got %0d expected 16", pulses); end
        checks++; if (cs_low[1] !== 68) begin errors++; $display("FAIL ps16_cs_low: got %0d expected 68", cs_low[1]); end
        checks++; if (send_msg !== miso_word) begin errors++; $display("FAIL ps16_send_msg: got %0h expected %0h", send_msg, miso_word); end
        ack();
        // a size write while busy must be ignored
        fork
            xfer($urandom, 1'b0, 6'd0, 1'b0, 2'd0, lat);
            begin
                repeat (10) @(posedge clk); #1;
                packet_size_val = 1'b1; packet_size_msg = 6'd5;
                @(posedge clk); #1;
                packet_size_val = 1'b0;
            end
        join
        checks++; if (pulses !== 16) begin errors++; $display("FAIL ps_busy_pulses: got %0d expected 16", pulses); end
        ack();
        xfer($urandom, 1'b0, 6'd0, 1'b0, 2'd0, lat);
        checks++; if (pulses !== 16) begin errors++; $display("FAIL ps_keep_pulses: got %0d expected 16", pulses); end
        ack();
        xfer($urandom, 1'b1, 6'd0, 1'b0, 2'd0, lat);
        checks++; if (pulses !== 32) begin errors++; $display("FAIL ps0_pulses: got %0d expected 32", pulses); end
        checks++; if (lat !== 133) begin errors++; $display("FAIL ps0_latency: got %0d expected 133", lat); end
        checks++; if (send_msg !== miso_word) begin errors++; $display("FAIL ps0_send_msg: got %0h expected %0h", send_msg, miso_word); end
        ack();
        xfer($urandom, 1'b1, 6'd40, 1'b0, 2'd0, lat);
        checks++; if (pulses !== 32) begin errors++; $display("FAIL ps40_pulses: got %0d expected 32", pulses); end
        ack();
    endtask

    task automatic test_random();
        int lat, n, bad;
        logic [1:0]  ca;
        logic [31:0] data;
        miso_mode = 0;
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 32); ca = 2'($urandom_range(0, 3)); data = $urandom;
            xfer(data, 1'b1, 6'(n), 1'b1, ca, lat);
            checks++; if (lat !== (2*n+2)*H+1) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", t, lat, (2*n+2)*H+1); end
            checks++; if (pulses !== n) begin errors++; $display("FAIL rnd%0d_pulses: got %0d expected %0d", t, pulses, n); end
            checks++; if (cs_low[ca] !== (2*n+2)*H) begin errors++; $display("FAIL rnd%0d_cs_low: got %0d expected %0d", t, cs_low[ca], (2*n+2)*H); end
            bad = 0;
            for (int i = 0; i < NCS; i++) if (i != int'(ca) && cs_low[i] != 0) bad++;
            checks++; if (bad !== 0) begin errors++; $display("FAIL rnd%0d_cs_other: got %0d lines expected 0", t, bad); end
            checks++; if (mosi_word !== (data & mask_n(n))) begin errors++; $display("FAIL rnd%0d_mosi: got %0h expected %0h", t, mosi_word, data & mask_n(n)); end
            checks++; if (send_msg !== miso_word) begin errors++; $display("FAIL rnd%0d_send_msg: got %0h expected %0h", t, send_msg, miso_word); end
            checks++; if (viol !== 0) begin errors++; $display("FAIL rnd%0d_mosi_edge: got %0d expected 0", t, viol); end
            ack();
        end
    endtask

    task automatic test_reset_abort();
        int found, bad;
        miso_mode = 0;
        @(posedge clk); #1;
        clear_mon();
        recv_val = 1'b1; recv_msg = $urandom; packet_size_val = 1'b1; packet_size_msg = 6'd8;
        @(posedge clk); #1;
        recv_val = 1'b0; packet_size_val = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (pulses == 3) begin found = 1; break; end
        end
        checks++; if (found !== 1) begin errors++; $display("FAIL ra_third_lead: got %0d expected 1", found); end
        reset = 1'b0;
        #1;
        checks++; if (cs !== 4'hF) begin errors++; $display("FAIL ra_cs: got %0h expected f", cs); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL ra_sclk: got %0b expected 0", sclk); end
        checks++; if (recv_rdy !== 1'b0) begin errors++; $display("FAIL ra_rdy_in_reset: got %0b expected 0", recv_rdy); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL ra_rdy: got %0b expected 1", recv_rdy); end
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL ra_send_val: got %0b expected 0", send_val); end
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (send_val !== 1'b0 || cs !== 4'hF) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL ra_no_response: got %0d bad cycles expected 0", bad); end
    endtask

`ifdef SPI_MASTER_MODE_EN
    task automatic test_mode3();
        int lat;
        cpol_tb = 1'b1; cpha_tb = 1'b1; miso_mode = 1;
        xfer(32'h3C, 1'b1, 6'd8, 1'b1, 2'd0, lat);
        checks++; if (lat !== 37) begin errors++; $display("FAIL m3_latency: got %0d expected 37", lat); end
        checks++; if (pulses !== 8) begin errors++; $display("FAIL m3_pulses: got %0d expected 8", pulses); end
        checks++; if (mosi_n !== 8 || mosi_word !== 32'h3C) begin errors++; $display("FAIL m3_mosi: got %0d bits %0h expected 8 bits 3c", mosi_n, mosi_word); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL m3_mosi_edge: got %0d expected 0", viol); end
        checks++; if (send_msg !== 32'h3C) begin errors++; $display("FAIL m3_send_msg: got %0h expected 3c", send_msg); end
        ack();
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL m3_idle_sclk: got %0b expected 1", sclk); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_mon();
        test_reset();
        test_mode0();
        test_size_cs();
        test_backpressure();
        test_packet_size();
        test_random();
        test_reset_abort();
`ifdef SPI_MASTER_MODE_EN
        test_mode3();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised SPI master: next-generation controller with configurable packet width, peripheral count and SCLK divider.
- Adds runtime packet length and chip-select addressing, and returns received MISO data on a val/rdy response interface.
- Sits between a val/rdy request source (e.g. a wishbone or router adapter) and off-chip SPI peripherals.

Parameters:
- BIT_WIDTH, 32, maximum bits per transaction; width of recv_msg and send_msg.
- N_CS, 1, number of peripheral chip-select lines.
- HALF_PERIOD, 2, clk cycles per SCLK half-period (>=1).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- recv_val  in  1  request valid.
- recv_rdy  out  1  request ready.
- recv_msg  in  BIT_WIDTH  data to transmit, right-aligned.
- send_val  out  1  response valid.
- send_rdy  in  1  response ready.
- send_msg  out  BIT_WIDTH  received data, right-aligned, upper bits zero.
- packet_size_val  in  1  packet-size write strobe.
- packet_size_msg  in  $clog2(BIT_WIDTH)+1  bits per transaction; 0 means BIT_WIDTH.
- cs_addr_val  in  1  chip-select address write strobe.
- cs_addr_msg  in  max(1,$clog2(N_CS))  index of peripheral to select.
- cs  out  N_CS  active-low chip selects.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data out, MSB of packet first.
- miso  in  1  serial data in.

Behaviour:
- Reset (async assert, sync deassert handled by caller):
  - state=IDLE, cs=all ones, sclk=0, mosi=0, send_val=0, recv_rdy=0 during reset, send_msg=0.
  - Registers reset to packet_size=BIT_WIDTH, cs_addr=0, mode=0.
  - Reset asserted mid-transaction aborts immediately: cs deasserts and no response is produced.
- Config registers:
  - Written only in IDLE when the corresponding *_val=1; ignored in other states.
  - A write in the same cycle as a recv handshake applies to that transaction (bypass).
- States: IDLE, START, LEAD, TRAIL, CS_WAIT, DONE. N = effective packet size; H = HALF_PERIOD.
- IDLE:
  - recv_rdy=1; all other outputs idle.
  - On recv_val&&recv_rdy at edge T: latch recv_msg[N-1:0] into the shift register, clear the rx register, go to START.
- START (H cycles, entered at T+1):
  - cs[cs_addr]=0; sclk=CPOL.
  - mosi=bit N-1 when CPHA=0; holds 0 when CPHA=1.
- LEAD (H cycles): sclk=~CPOL.
  - CPHA=1: mosi advances to the next bit at LEAD entry.
- TRAIL (H cycles): sclk=CPOL.
  - CPHA=0: miso sampled at LEAD->TRAIL edge; mosi advances at the same edge, except after the last bit, where mosi holds.
  - CPHA=1: miso sampled at TRAIL exit edge.
- Bit counter:
  - Increments once per TRAIL exit.
  - After the N-th TRAIL: go to CS_WAIT; otherwise go to LEAD.
- CS_WAIT (H cycles): cs still asserted, sclk=CPOL.
- DONE:
  - cs all ones; send_val=1; send_msg = rx bits right-aligned.
  - Holds until send_rdy=1, then returns to IDLE (recv_rdy=1 the next cycle).
  - Back-pressure indefinitely stalls DONE; a new request is not accepted.
- Timing:
  - cs low for exactly (2N+2)*H cycles.
  - Exactly N SCLK pulses per transaction.
  - Earliest next accept is 1 cycle after the send handshake.
- Boundary conditions:
  - packet_size_msg > BIT_WIDTH saturates to BIT_WIDTH.
  - cs_addr >= N_CS: no cs line asserts, but the transaction still runs and returns miso data.
  - Phase timer wraps at H-1; H=1 yields SCLK = clk/2.

Optional Feature:
- Macro: SPI_MASTER_MODE_EN.
- Defined: adds input ports cpol (1) and cpha (1).
  - Values are latched into the mode register at the recv handshake and held for the whole transaction.
  - Idle sclk after the transaction equals the latched CPOL.
- Undefined: ports absent; CPOL=0 and CPHA=0 are fixed (SPI mode 0).

Test Plan:
- Mode 0, H=2, N=8, recv_msg=0xA5, miso loopback from mosi:
  - cs low 36 cycles, 8 sclk pulses, mosi sequence 1,0,1,0,0,1,0,1.
  - send_msg=0x000000A5.
- packet_size=4, cs_addr=2 (N_CS=4), recv_msg=0xF3, miso tied 1:
  - Only cs[2] low; 4 pulses; mosi 0,0,1,1.
  - send_msg=0xF.
- send_rdy held 0 for 10 cycles after DONE:
  - send_val stays 1, recv_rdy stays 0, no new sclk edges.
  - Handshake on cycle 11; recv_rdy=1 on the next cycle.
- Reset driven low during the 3rd LEAD:
  - cs=all ones and sclk=0 in the same cycle.
  - After release: IDLE, recv_rdy=1, send_val=0.
- packet_size_val=1 with msg=16 in the same cycle as recv handshake: the transaction issues 16 sclk pulses; packet_size_msg=0 issues BIT_WIDTH pulses.
- SPI_MASTER_MODE_EN, cpol=1, cpha=1, N=8, loopback 0x3C:
  - sclk idles 1; mosi changes on falling sclk.
  - send_msg=0x3C.
